// File: rtl/md_unit_pkg.sv
// Shared multiply/divide definitions: op codes issued by EX and default latencies.
package md_unit_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_res_t;

endpackage

// File: rtl/md_unit.sv
// Fixed-latency multiply/divide unit: latches the result at issue, holds busy
// for the op latency, then commits it to the architectural HI/LO registers.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_dz;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;
    md_res_t             r_res;

    logic                w_accept;
    logic                w_div_ovf;
    logic                w_dz;
    logic signed [63:0]  w_a_s64;
    logic signed [63:0]  w_b_s64;
    logic signed [63:0]  w_prod_s;
    logic [63:0]         w_prod_u;
    logic signed [31:0]  w_a_s;
    logic signed [31:0]  w_b_s;
    logic signed [31:0]  w_quo_s;
    logic signed [31:0]  w_rem_s;
    logic [31:0]         w_b_u;
    md_res_t             w_res;

    assign w_accept = start && !req && !r_busy;

    assign w_a_s64  = $signed({{32{a[31]}}, a});
    assign w_b_s64  = $signed({{32{b[31]}}, b});
    assign w_prod_s = w_a_s64 * w_b_s64;
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Divisor is replaced by 1 for b==0 and for INT_MIN/-1 so the operator never
    // traps; both cases are resolved explicitly below.
    assign w_div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign w_dz      = (b == 32'd0);
    assign w_a_s     = $signed(a);
    assign w_b_s     = (w_dz || w_div_ovf) ? 32'sd1 : $signed(b);
    assign w_quo_s   = w_a_s / w_b_s;
    assign w_rem_s   = w_a_s % w_b_s;
    assign w_b_u     = w_dz ? 32'd1 : b;

    always_comb begin
        w_res = '0;
        case (op)
            MD_MULT:  w_res = md_res_t'(w_prod_s);
            MD_MULTU: w_res = md_res_t'(w_prod_u);
            MD_DIV: begin
                if (w_div_ovf) begin
                    w_res.lo = 32'h8000_0000;
                    w_res.hi = 32'd0;
                end else begin
                    w_res.lo = w_quo_s;
                    w_res.hi = w_rem_s;
                end
            end
            MD_DIVU: begin
                w_res.lo = a / w_b_u;
                w_res.hi = a % w_b_u;
            end
            default: w_res = '0;
        endcase
    end

    // IDLE/RUN is encoded by r_cnt != 0; the accept edge loads the latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_dz   <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_res  <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
                if (!r_dz) begin
                    r_hi <= r_res.hi;
                    r_lo <= r_res.lo;
                end
            end
        end else if (w_accept) begin
            case (op)
                MD_MULT, MD_MULTU: begin
                    r_res  <= w_res;
                    r_dz   <= 1'b0;
                    r_cnt  <= CNT_W'(MULT_CYCLES);
                    r_busy <= 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                    r_res  <= w_res;
                    r_dz   <= w_dz;
                    r_cnt  <= CNT_W'(DIV_CYCLES);
                    r_busy <= 1'b1;
                end
                MD_MTHI: r_hi <= a;
                MD_MTLO: r_lo <= a;
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: reset, each arithmetic op, divide corner cases,
// flush interaction and issue-while-busy.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        req;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec;
    int n_err;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .req   (req),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one issue cycle; returns one cycle after the issue edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic rq);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        req   = rq;
        step();
        start = 1'b0;
        op    = MD_NONE;
        req   = 1'b0;
    endtask

    // Counts cycles busy reads 1, bounded so a stuck busy cannot hang the run.
    task automatic run_count(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            step();
        end
    endtask

    task automatic test_reset();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL rst_hi: got %h want 0", hi); end
        n_vec++; if (lo !== 32'd0) begin n_err++; $display("FAIL rst_lo: got %h want 0", lo); end
        issue(MD_MTHI, 32'hAAAA_0001, 32'd0, 1'b0);
        issue(MD_MTLO, 32'hBBBB_0002, 32'd0, 1'b0);
        issue(MD_MULT, 32'd3, 32'd4, 1'b0);
        step();
        #2 reset = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_rst_busy: got %b want 0", busy); end
        n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL async_rst_hi: got %h want 0", hi); end
        n_vec++; if (lo !== 32'd0) begin n_err++; $display("FAIL async_rst_lo: got %h want 0", lo); end
        step();
        reset = 1'b1;
        step();
        n_vec++; if (hi !== 32'd0 || lo !== 32'd0) begin n_err++;
            $display("FAIL rst_abort: got hi=%h lo=%h want 0/0", hi, lo); end
        issue(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        n_vec++; if (hi !== 32'h1234_5678) begin n_err++; $display("FAIL mthi: got %h want 12345678", hi); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy: got %b want 0", busy); end
    endtask

    task automatic test_mult();
        int cyc;
        issue(MD_MTHI, 32'd0, 32'd0, 1'b0);
        issue(MD_MTLO, 32'd0, 32'd0, 1'b0);
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        n_vec++; if (hi !== 32'd0 || lo !== 32'd0) begin n_err++;
            $display("FAIL mult_early: got hi=%h lo=%h want 0/0", hi, lo); end
        run_count(cyc);
        n_vec++; if (cyc != 5) begin n_err++; $display("FAIL mult_busy: got %0d want 5", cyc); end
        n_vec++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_vec++; if (lo !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
    endtask

    task automatic test_multu();
        int cyc;
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_count(cyc);
        n_vec++; if (cyc != 5) begin n_err++; $display("FAIL multu_busy: got %0d want 5", cyc); end
        n_vec++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        n_vec++; if (lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    endtask

    task automatic test_div();
        int cyc;
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_count(cyc);
        n_vec++; if (cyc != 10) begin n_err++; $display("FAIL div_busy: got %0d want 10", cyc); end
        n_vec++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        n_vec++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        issue(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_count(cyc);
        n_vec++; if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin n_err++;
            $display("FAIL div_negdivisor: got hi=%h lo=%h want 00000001/fffffffd", hi, lo); end
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_count(cyc);
        n_vec++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin n_err++;
            $display("FAIL div_ovf: got hi=%h lo=%h want 00000000/80000000", hi, lo); end
        issue(MD_DIVU, 32'd100, 32'd7, 1'b0);
        run_count(cyc);
        n_vec++; if (cyc != 10) begin n_err++; $display("FAIL divu_busy: got %0d want 10", cyc); end
        n_vec++; if (lo !== 32'd14 || hi !== 32'd2) begin n_err++;
            $display("FAIL divu: got hi=%h lo=%h want 00000002/0000000e", hi, lo); end
    endtask

    task automatic test_divzero();
        int cyc;
        issue(MD_MTHI, 32'd5, 32'd0, 1'b0);
        issue(MD_MTLO, 32'd6, 32'd0, 1'b0);
        issue(MD_DIVU, 32'd1234, 32'd0, 1'b0);
        run_count(cyc);
        n_vec++; if (cyc != 10) begin n_err++; $display("FAIL divz_busy: got %0d want 10", cyc); end
        n_vec++; if (hi !== 32'd5 || lo !== 32'd6) begin n_err++;
            $display("FAIL divz_keep: got hi=%h lo=%h want 00000005/00000006", hi, lo); end
    endtask

    task automatic test_req();
        int cyc;
        issue(MD_MTHI, 32'd1, 32'd0, 1'b0);
        issue(MD_MTLO, 32'd2, 32'd0, 1'b0);
        issue(MD_MULT, 32'd3, 32'd4, 1'b1);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL req_drop_busy: got %b want 0", busy); end
        repeat (6) step();
        n_vec++; if (hi !== 32'd1 || lo !== 32'd2) begin n_err++;
            $display("FAIL req_drop: got hi=%h lo=%h want 00000001/00000002", hi, lo); end
        issue(MD_DIV, 32'd20, 32'd3, 1'b0);
        step();
        step();
        req = 1'b1;
        step();
        req = 1'b0;
        run_count(cyc);
        cyc += 3;
        n_vec++; if (cyc != 10) begin n_err++; $display("FAIL req_inflight_busy: got %0d want 10", cyc); end
        n_vec++; if (lo !== 32'd6 || hi !== 32'd2) begin n_err++;
            $display("FAIL req_inflight: got hi=%h lo=%h want 00000002/00000006", hi, lo); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        issue(MD_MULT, 32'd6, 32'd7, 1'b0);
        issue(MD_DIVU, 32'd9, 32'd2, 1'b0);
        run_count(cyc);
        n_vec++; if (cyc != 4) begin n_err++; $display("FAIL b2b_busy: got %0d want 4", cyc); end
        n_vec++; if (lo !== 32'd42 || hi !== 32'd0) begin n_err++;
            $display("FAIL b2b_result: got hi=%h lo=%h want 00000000/0000002a", hi, lo); end
        step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_not_queued: got %b want 0", busy); end
    endtask

    task automatic test_bad_ops();
        issue(MD_NONE, 32'hDEAD_BEEF, 32'd1, 1'b0);
        issue(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL badop_busy: got %b want 0", busy); end
        n_vec++; if (lo !== 32'd42 || hi !== 32'd0) begin n_err++;
            $display("FAIL badop_keep: got hi=%h lo=%h want 00000000/0000002a", hi, lo); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        start = 1'b0;
        op    = MD_NONE;
        a     = '0;
        b     = '0;
        req   = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        step();
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divzero();
        test_req();
        test_back_to_back();
        test_bad_ops();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide responder for the EX stage. EX issues a single-cycle `start` with an op and two forwarded operands.
- The unit runs a fixed-latency operation, holds `busy` while it runs, then commits the result to the architectural HI/LO registers.
- The hazard unit uses `busy` to stall mf/mt/mult/div instructions in D.
- `req` (exception/interrupt flush) cancels an issue that arrives in the same cycle.

Parameters:
- MULT_CYCLES, 5, cycles busy is held for mult/multu (must be ≥1).
- DIV_CYCLES, 10, cycles busy is held for div/divu (must be ≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  issue strobe from EX; one cycle per instruction.
- op  in  3  operation code, `MD_*` from the shared package.
- a  in  32  operand A (rs, forwarded).
- b  in  32  operand B (rt, forwarded).
- req  in  1  exception/interrupt flush request from CP0.
- busy  out  1  registered; high while an operation is in flight.
- hi  out  32  architectural HI register.
- lo  out  32  architectural LO register.

Behaviour:
- Reset (reset==0, asynchronous): hi=0, lo=0, busy=0, counter=0, temporary result regs=0. Reset mid-operation aborts it; HI/LO stay 0.
- Accept condition: start && !req && !busy. If not met, the issue is ignored with no state change. The hazard unit guarantees no start while busy; that case is still ignored, not queued.
- MD_MULT: {hi_t,lo_t} = $signed(a)*$signed(b), full 64 bits.
- MD_MULTU: {hi_t,lo_t} = a*b, unsigned, full 64 bits.
- MD_DIV: lo_t = $signed(a)/$signed(b), hi_t = $signed(a)%$signed(b). Quotient truncates toward zero; remainder takes the sign of the dividend.
- MD_DIVU: lo_t = a/b, hi_t = a%b, unsigned.
- Divide by zero (b==0) on div/divu: the op is accepted and busy runs its full DIV_CYCLES, but HI/LO are left unchanged at commit.
- Overflow: 0x80000000 / 0xFFFFFFFF (div) gives lo=0x80000000, hi=0.
- Multicycle timing: on the accept edge, temps are latched, counter <= N, busy <= 1.
  - busy reads 1 for exactly N cycles after the accept edge.
  - On the edge where counter==1: hi<=hi_t, lo<=lo_t, busy<=0, counter<=0.
  - New HI/LO are visible in the first cycle busy reads 0.
- MD_MTHI / MD_MTLO: on the accept edge, hi<=a or lo<=a respectively. busy is not asserted.
- MD_NONE (0), or codes 7 and above: ignored.
- req while busy: the in-flight op is not cancelled and commits normally, because its instruction has already left E. Only the same-cycle issue is dropped.
- No outputs are combinational from inputs; busy, hi and lo are all registers.

Decomposition:
- Shared package/header (alongside the onehot definitions) holds:
  - `MD_NONE`=0, `MD_MULT`=1, `MD_MULTU`=2, `MD_DIV`=3, `MD_DIVU`=4, `MD_MTHI`=5, `MD_MTLO`=6;
  - the latency defaults.
- The EX pipeline stage derives `op` from its onehot decode.
- No sub-module is needed. The arithmetic is behavioural operators, with a small down-counter FSM (IDLE/RUN, encoded by counter!=0) in the same module.

Test Plan:
- Reset low mid-run → busy=0, hi=lo=0 immediately, without waiting for a clock edge. Reset high, then MTHI a=0x12345678 → hi=0x12345678 the next cycle, busy never 1.
- MULT a=0xFFFFFFFE (−2), b=3 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=−7 (0xFFFFFFF9), b=2 → busy high exactly 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU with b=0 after presetting hi=5, lo=6 → busy high 10 cycles; then hi=5, lo=6 unchanged.
- start+MULT with req=1 in the same cycle → busy stays 0, HI/LO unchanged. Separately, DIV accepted, then req pulsed on cycle 3 → the DIV still commits on schedule. A start during busy → ignored, and the original result commits.
